// File: rtl/crypto_result_buffer.sv
// ============================================================================
// crypto_result_buffer
// ----------------------------------------------------------------------------
// Sits between the crypto scalar functional unit and the CVXIF result channel.
// The FU produces single-cycle result pulses and cannot be stalled. This
// block queues those results in a small FIFO and offers them to the core
// through a valid/ready handshake. A credit counter tells the decoder whether
// a result slot is guaranteed, so legal traffic never overflows the FIFO.
//
// Handshake rule (result channel): a transfer happens on a rising clock edge
// where result_valid_o && result_ready_i. Once result_valid_o is high, it and
// every result_* field hold steady until that transfer edge. result_ready_i
// may be high before valid and has no effect while valid is low.
//
// Ports:
//   clk_i            clock, all state changes on the rising edge
//   rst_i            synchronous, active-high reset
//   issue_fire_i     decoder accepted an instruction that yields one result
//   issue_allow_o    a credit is free; decoder gates its issue_ready with this
//   fu_valid_i       one-cycle result pulse from the FU (no backpressure)
//   fu_hartid_i      result hartid
//   fu_id_i          result instruction id
//   fu_data_i        result data
//   fu_rd_i          destination register
//   fu_we_i          register write enable
//   result_valid_o   CVXIF result valid (FIFO not empty)
//   result_ready_i   CVXIF result ready from the core
//   result_hartid_o  head entry hartid (0 when empty)
//   result_id_o      head entry id (0 when empty)
//   result_data_o    head entry data (0 when empty)
//   result_rd_o      head entry rd (0 when empty)
//   result_we_o      head entry we (0 when empty)
//   count_o          current FIFO occupancy
//   overflow_o       sticky protocol-error flag, cleared only by reset
// ============================================================================
module crypto_result_buffer #(
    parameter int unsigned XLEN        = 64,
    parameter int unsigned Depth       = 4,
    parameter int unsigned HartIdWidth = 1,
    parameter int unsigned IdWidth     = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,

    input  logic                       issue_fire_i,
    output logic                       issue_allow_o,

    input  logic                       fu_valid_i,
    input  logic [HartIdWidth-1:0]     fu_hartid_i,
    input  logic [IdWidth-1:0]         fu_id_i,
    input  logic [XLEN-1:0]            fu_data_i,
    input  logic [4:0]                 fu_rd_i,
    input  logic                       fu_we_i,

    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [HartIdWidth-1:0]     result_hartid_o,
    output logic [IdWidth-1:0]         result_id_o,
    output logic [XLEN-1:0]            result_data_o,
    output logic [4:0]                 result_rd_o,
    output logic                       result_we_o,

    output logic [$clog2(Depth):0]     count_o,
    output logic                       overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    // ------------------------------------------------------------------------
    // Storage. Each field lives in its own array; none of it needs a reset
    // because the outputs are forced to zero whenever the FIFO is empty.
    // ------------------------------------------------------------------------
    logic [HartIdWidth-1:0] hartid_mem [Depth];
    logic [IdWidth-1:0]     id_mem     [Depth];
    logic [XLEN-1:0]        data_mem   [Depth];
    logic [4:0]             rd_mem     [Depth];
    logic                   we_mem     [Depth];

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;
    logic [CntW-1:0] credits;
    logic            overflow;

    logic [PtrW-1:0] rd_ptr_next;
    logic [PtrW-1:0] wr_ptr_next;
    logic [CntW-1:0] count_next;
    logic [CntW-1:0] credits_next;

    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic push_drop;
    logic credit_err;

    assign not_empty = (count != '0);
    assign full      = (count == DepthCnt);
    assign pop       = not_empty && result_ready_i;

    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle; otherwise the entry has nowhere to go and is dropped.
    assign push      = fu_valid_i && (!full || pop);
    assign push_drop = fu_valid_i && full && !pop;

    // ------------------------------------------------------------------------
    // Pointer / occupancy next-state
    // ------------------------------------------------------------------------
    always_comb begin
        rd_ptr_next = rd_ptr;
        wr_ptr_next = wr_ptr;
        count_next  = count;

        // Depth is a power of two, so natural pointer overflow wraps
        // modulo Depth.
        if (pop) begin
            rd_ptr_next = rd_ptr + PtrOne;
        end
        if (push) begin
            wr_ptr_next = wr_ptr + PtrOne;
        end

        if (push && !pop) begin
            count_next = count + CntOne;
        end else if (pop && !push) begin
            count_next = count - CntOne;
        end
    end

    // ------------------------------------------------------------------------
    // Credit counter next-state. Fire and pop in the same cycle cancel out.
    // Fire at the ceiling or pop at zero is a decoder/FU protocol error: the
    // counter holds and the sticky flag is raised.
    // ------------------------------------------------------------------------
    always_comb begin
        credits_next = credits;
        credit_err   = 1'b0;

        if (issue_fire_i && !pop) begin
            if (credits == DepthCnt) begin
                credit_err = 1'b1;
            end else begin
                credits_next = credits + CntOne;
            end
        end else if (pop && !issue_fire_i) begin
            if (credits == '0) begin
                credit_err = 1'b1;
            end else begin
                credits_next = credits - CntOne;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            credits  <= '0;
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_ptr_next;
            wr_ptr   <= wr_ptr_next;
            count    <= count_next;
            credits  <= credits_next;
            overflow <= overflow | push_drop | credit_err;
        end
    end

    // Writes are suppressed during reset so a pulse in the reset cycle
    // leaves no trace, even in the storage array.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            hartid_mem[wr_ptr] <= fu_hartid_i;
            id_mem[wr_ptr]     <= fu_id_i;
            data_mem[wr_ptr]   <= fu_data_i;
            rd_mem[wr_ptr]     <= fu_rd_i;
            we_mem[wr_ptr]     <= fu_we_i;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The result fields come only from the registered head entry,
    // so a new push is visible no earlier than the following cycle and the
    // fields cannot move while valid is held without ready.
    // ------------------------------------------------------------------------
    assign result_valid_o  = not_empty;
    assign result_hartid_o = not_empty ? hartid_mem[rd_ptr] : '0;
    assign result_id_o     = not_empty ? id_mem[rd_ptr]     : '0;
    assign result_data_o   = not_empty ? data_mem[rd_ptr]   : '0;
    assign result_rd_o     = not_empty ? rd_mem[rd_ptr]     : '0;
    assign result_we_o     = not_empty ? we_mem[rd_ptr]     : 1'b0;

    assign issue_allow_o   = (credits < DepthCnt);
    assign count_o         = count;
    assign overflow_o      = overflow;

endmodule

// File: tb/tb_crypto_result_buffer.sv
// ============================================================================
// tb_crypto_result_buffer
// ----------------------------------------------------------------------------
// Bench for crypto_result_buffer. Results driven into the FU side are pushed
// onto an expected queue; a negedge monitor pops and compares whenever the
// result channel transfers. Directed sections cover reset, single result,
// backpressure, full with simultaneous push/pop, protocol errors and reset
// mid-operation, followed by a short random phase.
// ============================================================================
module tb_crypto_result_buffer;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned HW    = 1;
    localparam int unsigned IW    = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    // ------------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------------
    logic            issue_fire = 1'b0;
    logic            issue_allow;
    logic            fu_valid = 1'b0;
    logic [HW-1:0]   fu_hartid = '0;
    logic [IW-1:0]   fu_id = '0;
    logic [XLEN-1:0] fu_data = '0;
    logic [4:0]      fu_rd = '0;
    logic            fu_we = 1'b0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [HW-1:0]   result_hartid;
    logic [IW-1:0]   result_id;
    logic [XLEN-1:0] result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic [CW-1:0]   count;
    logic            overflow;

    crypto_result_buffer #(
        .XLEN        (XLEN),
        .Depth       (DEPTH),
        .HartIdWidth (HW),
        .IdWidth     (IW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .issue_fire_i    (issue_fire),
        .issue_allow_o   (issue_allow),
        .fu_valid_i      (fu_valid),
        .fu_hartid_i     (fu_hartid),
        .fu_id_i         (fu_id),
        .fu_data_i       (fu_data),
        .fu_rd_i         (fu_rd),
        .fu_we_i         (fu_we),
        .result_valid_o  (result_valid),
        .result_ready_i  (result_ready),
        .result_hartid_o (result_hartid),
        .result_id_o     (result_id),
        .result_data_o   (result_data),
        .result_rd_o     (result_rd),
        .result_we_o     (result_we),
        .count_o         (count),
        .overflow_o      (overflow)
    );

    // ------------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------------
    logic [79:0] exp_q[$];
    logic [79:0] mon_exp;
    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [79:0] pack(input logic [HW-1:0] h, input logic [IW-1:0] id,
                                         input logic [4:0] rd, input logic we,
                                         input logic [XLEN-1:0] d);
        pack = {6'b0, h, id, rd, we, d};
    endfunction

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Every transfer on the result channel must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 80'd1, 80'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("pop_entry",
                      pack(result_hartid, result_id, result_rd, result_we, result_data),
                      mon_exp);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fu_valid   = 1'b0;
        issue_fire = 1'b0;
    endtask

    task automatic drive_result(input logic [XLEN-1:0] d, input logic [IW-1:0] id,
                                input logic [4:0] rd, input logic we,
                                input logic [HW-1:0] h, input bit keep);
        fu_valid  = 1'b1;
        fu_data   = d;
        fu_id     = id;
        fu_rd     = rd;
        fu_we     = we;
        fu_hartid = h;
        if (keep) exp_q.push_back(pack(h, id, rd, we, d));
    endtask

    // Issue and produce n results (data base..base+n-1) with ready held low.
    task automatic fill(input int n, input logic [XLEN-1:0] base);
        result_ready = 1'b0;
        for (int k = 0; k < n; k++) begin
            issue_fire = 1'b1;
            drive_result(base + XLEN'(k), 3'(k), 5'(k + 1), 1'b1, 1'b0, 1'b1);
            cycle();
        end
        idle_inputs();
    endtask

    task automatic drain(input int n);
        result_ready = 1'b1;
        repeat (n) cycle();
        result_ready = 1'b0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        // Reset and idle
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        repeat (5) cycle();
        check("rst_valid",    80'(result_valid), 80'd0);
        check("rst_allow",    80'(issue_allow),  80'd1);
        check("rst_count",    80'(count),        80'd0);
        check("rst_overflow", 80'(overflow),     80'd0);
        check("rst_data",     80'(result_data),  80'd0);

        // Single result path: fire at cycle 0, result at cycle 2, out at 3
        result_ready = 1'b1;
        issue_fire = 1'b1;
        cycle();
        issue_fire = 1'b0;
        cycle();
        drive_result(64'hDEAD_BEEF, 3'd2, 5'd7, 1'b1, 1'b0, 1'b1);
        check("single_c2_valid", 80'(result_valid), 80'd0);
        cycle();
        idle_inputs();
        check("single_c3_valid", 80'(result_valid), 80'd1);
        check("single_c3_fields",
              pack(result_hartid, result_id, result_rd, result_we, result_data),
              pack(1'b0, 3'd2, 5'd7, 1'b1, 64'hDEAD_BEEF));
        cycle();
        check("single_c4_valid", 80'(result_valid), 80'd0);
        check("single_c4_count", 80'(count),        80'd0);
        check("single_c4_allow", 80'(issue_allow),  80'd1);

        // Full-depth backpressure
        fill(4, 64'd1);
        check("bp_count", 80'(count),       80'd4);
        check("bp_allow", 80'(issue_allow), 80'd0);
        for (int i = 0; i < 10; i++) begin
            check("bp_head_valid", 80'(result_valid), 80'd1);
            check("bp_head_data",  80'(result_data),  80'd1);
            cycle();
        end
        result_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain_count", 80'(count), 80'(4 - i));
            cycle();
        end
        result_ready = 1'b0;
        check("bp_end_count", 80'(count),       80'd0);
        check("bp_end_allow", 80'(issue_allow), 80'd1);

        // Full with simultaneous push and pop
        fill(4, 64'd1);
        issue_fire   = 1'b1;
        result_ready = 1'b1;
        drive_result(64'd5, 3'd4, 5'd9, 1'b0, 1'b1, 1'b1);
        cycle();
        idle_inputs();
        result_ready = 1'b0;
        check("fullpp_count",    80'(count),       80'd4);
        check("fullpp_overflow", 80'(overflow),    80'd0);
        check("fullpp_allow",    80'(issue_allow), 80'd0);
        check("fullpp_head",     80'(result_data), 80'd2);
        drain(4);
        check("fullpp_end_count",    80'(count),    80'd0);
        check("fullpp_end_overflow", 80'(overflow), 80'd0);

        // Protocol errors: push into full FIFO, then fire at the credit ceiling
        fill(4, 64'h10);
        drive_result(64'h14, 3'd5, 5'd3, 1'b1, 1'b0, 1'b0);
        cycle();
        idle_inputs();
        check("drop_overflow", 80'(overflow),    80'd1);
        check("drop_count",    80'(count),       80'd4);
        check("drop_head",     80'(result_data), 80'h10);
        issue_fire = 1'b1;
        cycle();
        issue_fire = 1'b0;
        check("credit_ceiling_allow", 80'(issue_allow), 80'd0);
        drain(4);
        check("perr_drain_count", 80'(count),       80'd0);
        check("perr_drain_allow", 80'(issue_allow), 80'd1);
        check("overflow_sticky",  80'(overflow),    80'd1);
        // Credits must be back at exactly 0: three fires leave room, four do not.
        issue_fire = 1'b1;
        repeat (3) cycle();
        issue_fire = 1'b0;
        check("credit_3_allow", 80'(issue_allow), 80'd1);
        issue_fire = 1'b1;
        cycle();
        issue_fire = 1'b0;
        check("credit_4_allow", 80'(issue_allow), 80'd0);
        for (int k = 0; k < 4; k++) begin
            drive_result(64'h20 + 64'(k), 3'(k), 5'(k), 1'b0, 1'b1, 1'b1);
            cycle();
        end
        idle_inputs();
        drain(4);
        check("credit_ret_allow", 80'(issue_allow), 80'd1);
        check("credit_ret_count", 80'(count),       80'd0);

        // Reset mid-operation, with pulses in the reset cycle that must be ignored
        fill(3, 64'h30);
        check("pre_rst_count", 80'(count), 80'd3);
        rst = 1'b1;
        issue_fire = 1'b1;
        drive_result(64'h99, 3'd1, 5'd1, 1'b1, 1'b0, 1'b0);
        exp_q.delete();
        cycle();
        rst = 1'b0;
        idle_inputs();
        check("midrst_valid",    80'(result_valid), 80'd0);
        check("midrst_count",    80'(count),        80'd0);
        check("midrst_allow",    80'(issue_allow),  80'd1);
        check("midrst_overflow", 80'(overflow),     80'd0);
        check("midrst_data",     80'(result_data),  80'd0);
        cycle();
        check("midrst_next_valid", 80'(result_valid), 80'd0);

        // Random legal traffic: each fire carries its result in the same cycle,
        // so credits always equal occupancy.
        for (int c = 0; c < 60; c++) begin
            check("rand_count", 80'(count),       80'(exp_q.size()));
            check("rand_allow", 80'(issue_allow), 80'(exp_q.size() < DEPTH));
            result_ready = 1'($urandom_range(0, 1));
            if (exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
                issue_fire = 1'b1;
                drive_result({$urandom, $urandom}, 3'($urandom_range(0, 7)),
                             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                             1'($urandom_range(0, 1)), 1'b1);
            end else begin
                idle_inputs();
            end
            cycle();
        end
        idle_inputs();
        drain(DEPTH + 1);
        check("rand_end_count",    80'(count),        80'd0);
        check("rand_end_queue",    80'(exp_q.size()), 80'd0);
        check("rand_end_overflow", 80'(overflow),     80'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/crypto_result_buffer.md
Name: crypto_result_buffer

Overview:
- Result-side stage placed directly downstream of the crypto scalar functional unit, between the FU result outputs and the CVXIF result channel.
- The FU emits one-cycle result pulses with no backpressure. This block queues them in a FIFO and presents them to the core with a proper valid/ready handshake.
- It also runs a credit counter so the instruction decoder only accepts an instruction when a result slot is guaranteed.

Parameters:
- XLEN, 64, result data width.
- Depth, 4, number of FIFO entries and issue credits; power of two, at least 2.
- HartIdWidth, 1, width of the hartid field.
- IdWidth, 3, width of the instruction id field.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- issue_fire_i  in  1  the decoder accepted an instruction that will produce exactly one result.
- issue_allow_o  out  1  a credit is available; the decoder gates issue_ready with this.
- fu_valid_i  in  1  single-cycle result pulse from the FU.
- fu_hartid_i  in  HartIdWidth  result hartid.
- fu_id_i  in  IdWidth  result id.
- fu_data_i  in  XLEN  result data.
- fu_rd_i  in  5  destination register.
- fu_we_i  in  1  register write enable.
- result_valid_o  out  1  CVXIF result valid.
- result_ready_i  in  1  CVXIF result ready from the core.
- result_hartid_o  out  HartIdWidth  head entry hartid.
- result_id_o  out  IdWidth  head entry id.
- result_data_o  out  XLEN  head entry data.
- result_rd_o  out  5  head entry rd.
- result_we_o  out  1  head entry we.
- count_o  out  $clog2(Depth)+1  current FIFO occupancy.
- overflow_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_i high at a clock edge):
  - Read pointer, write pointer, count, credit counter and overflow_o all go to 0.
  - Outputs then read result_valid_o=0, issue_allow_o=1, count_o=0.
  - Reset mid-operation discards all queued entries and credits. Any fu_valid_i or issue_fire_i in the reset cycle is ignored.
- Push and pop:
  - Push: fu_valid_i=1 writes {hartid,id,data,rd,we} at the write pointer.
  - Pop: result_valid_o && result_ready_i.
  - Pointers wrap modulo Depth.
- Latency: a pushed entry into an empty FIFO appears on result_valid_o the next cycle. There is no combinational bypass from fu_* to result_*.
- result_valid_o = (count != 0). Result fields show the head entry and are driven to 0 when empty.
- Handshake: once result_valid_o is asserted, it and all result fields stay stable until the pop cycle. result_ready_i may be asserted before valid.
- Simultaneous push and pop:
  - Count is unchanged; both pointers advance.
  - Allowed when full, because the pop frees the slot.
  - Not possible when empty, since valid is low.
- Push when full without a pop: the entry is dropped, state is unchanged, and overflow_o is set.
- Credit counter, range 0..Depth:
  - Increments on issue_fire_i and decrements on pop; no change when both occur in the same cycle.
  - issue_allow_o = (credits < Depth), combinational from the registered counter.
  - issue_fire_i while credits==Depth without a pop: ignored and sets overflow_o.
  - A pop while credits==0 sets overflow_o, and the counter holds at 0.
- overflow_o is sticky until reset. It never blocks normal operation.
- Invariant in legal operation: count <= credits <= Depth.

Test Plan:
- Reset, then idle 5 cycles → result_valid_o=0, issue_allow_o=1, count_o=0, overflow_o=0, result_data_o=0.
- Single result path:
  - Stimulus: issue_fire_i at cycle 0; fu_valid_i with data=0xDEAD_BEEF, id=2, rd=7, we=1 at cycle 2; result_ready_i=1 throughout.
  - Response: result_valid_o high only in cycle 3 with the matching fields; credits return to 0 at cycle 4.
- Full-depth backpressure:
  - Stimulus: 4 issues and 4 results (data 1..4) with result_ready_i=0.
  - Response: count_o=4, issue_allow_o=0, head data=1 stable for 10 cycles; then ready=1 drains 1,2,3,4 on consecutive cycles and issue_allow_o returns to 1.
- Full with simultaneous push and pop:
  - Stimulus: FIFO full with 1..4; in one cycle fu_valid_i data=5 and result_ready_i=1.
  - Response: count_o stays 4, overflow_o=0, drain order is 2,3,4,5.
- Protocol errors:
  - Push 5 results into a full FIFO without popping → 5th is dropped and overflow_o=1 sticky.
  - issue_fire_i at credits==4 → counter stays 4.
- Reset mid-operation: with 3 entries queued, pulse rst_i for 1 cycle → result_valid_o=0, count_o=0, issue_allow_o=1 the cycle after reset.
